// File: rtl/nanci_pkg.sv
// Shared definitions for the sequenced mesh sorting PE: command and
// direction encodings, FSM states and word/key helpers.
package nanci_pkg;

  // Helpers work on words up to this many bits; callers cast in and out.
  localparam int KEY_MAX_W = 32;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_SHIFT   = 3'd2,
    OP_CX_MIN  = 3'd3,
    OP_CX_MAX  = 3'd4,
    OP_SAVE    = 3'd5,
    OP_RESTORE = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Extract the sort key (low dw bits) of a word.
  function automatic logic [KEY_MAX_W-1:0] key_of(input logic [KEY_MAX_W-1:0] word,
                                                  input int unsigned dw);
    logic [KEY_MAX_W-1:0] mask;
    mask = (dw >= KEY_MAX_W) ? '1 : ((KEY_MAX_W'(1) << dw) - KEY_MAX_W'(1));
    return word & mask;
  endfunction

  // Build {addr, data} with the data field dw bits wide.
  function automatic logic [KEY_MAX_W-1:0] pack_word(input logic [KEY_MAX_W-1:0] addr,
                                                     input logic [KEY_MAX_W-1:0] data,
                                                     input int unsigned dw);
    return (addr << dw) | key_of(data, dw);
  endfunction

endpackage

// File: rtl/nanci_pe_seq_if.sv
// Command port of the PE: valid/ready handshake plus the command fields.
interface nanci_pe_seq_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
);
  localparam int W      = ADDR_WIDTH + DATA_WIDTH;
  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [1:0]           cmd_dir;
  logic [SLOT_W-1:0]    cmd_slot;
  logic [CNT_WIDTH-1:0] cmd_count;
  logic [W-1:0]         cmd_word;

  // Sort controller side.
  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_slot, cmd_count, cmd_word,
    input  cmd_ready
  );

  // PE side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_slot, cmd_count, cmd_word,
    output cmd_ready
  );

endinterface

// File: rtl/nanci_cx_unit.sv
// Combinational neighbour select and compare-exchange. Produces the word the
// PE would hold after one SHIFT/CX_MIN/CX_MAX step; any other op passes the
// own word through unchanged.
module nanci_cx_unit
  import nanci_pkg::*;
#(
  parameter  int ADDR_WIDTH = 3,
  parameter  int DATA_WIDTH = 3,
  localparam int W          = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic [W-1:0] own_i,
  input  logic [W-1:0] l_i,
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] d_i,
  input  dir_e         dir_i,
  input  op_e          op_i,
  output logic [W-1:0] next_o
);

  logic [W-1:0]          nbr;
  logic [DATA_WIDTH-1:0] nbr_key;
  logic [DATA_WIDTH-1:0] own_key;

  // Pick the neighbour named by the held direction.
  always_comb begin
    nbr = l_i;
    case (dir_i)
      DIR_L:   nbr = l_i;
      DIR_R:   nbr = r_i;
      DIR_U:   nbr = u_i;
      DIR_D:   nbr = d_i;
      default: nbr = l_i;
    endcase
  end

  // Keys are compared unsigned at DATA_WIDTH; addr never takes part.
  assign nbr_key = DATA_WIDTH'(key_of(KEY_MAX_W'(nbr), DATA_WIDTH));
  assign own_key = DATA_WIDTH'(key_of(KEY_MAX_W'(own_i), DATA_WIDTH));

  // Strict compares so equal keys keep the own word (stable exchange).
  always_comb begin
    next_o = own_i;
    case (op_i)
      OP_SHIFT:  next_o = nbr;
      OP_CX_MIN: if (nbr_key < own_key) next_o = nbr;
      OP_CX_MAX: if (nbr_key > own_key) next_o = nbr;
      default:   next_o = own_i;
    endcase
  end

endmodule

// File: rtl/nanci_pe_seq.sv
// Sequenced mesh sorting PE: accepts one command in IDLE, applies it once per
// cycle for max(count,1) cycles in RUN, then pulses done. Holds the word in
// o_PE and a small save/restore slot file.
module nanci_pe_seq
  import nanci_pkg::*;
#(
  parameter  int ADDR_WIDTH = 3,
  parameter  int DATA_WIDTH = 3,
  parameter  int DEPTH      = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int W          = ADDR_WIDTH + DATA_WIDTH,
  localparam int SLOT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  nanci_pe_seq_if.slave      cmd,
  input  logic [W-1:0]       i_PE_l,
  input  logic [W-1:0]       i_PE_r,
  input  logic [W-1:0]       i_PE_u,
  input  logic [W-1:0]       i_PE_d,
  output logic [W-1:0]       o_PE,
  output logic               busy,
  output logic               done
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  dir_e                 dir_q, dir_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [W-1:0]         word_q, word_d;
  logic [CNT_WIDTH-1:0] iter_q, iter_d;
  logic [W-1:0]         pe_q, pe_d;
  logic                 done_q, done_d;

  logic [W-1:0]         slot_mem_q [DEPTH];
  logic [DEPTH-1:0]     slot_hit;
  logic                 save_en;
  logic [W-1:0]         restore_word;
  logic [W-1:0]         cx_word;

  // One-hot decode of the held slot index; out-of-range indices hit nothing,
  // which drops SAVE and makes RESTORE return zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_hit
    assign slot_hit[gi] = (slot_q == SLOT_W'(gi));
  end

  nanci_cx_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cx (
    .own_i  (pe_q),
    .l_i    (i_PE_l),
    .r_i    (i_PE_r),
    .u_i    (i_PE_u),
    .d_i    (i_PE_d),
    .dir_i  (dir_q),
    .op_i   (op_q),
    .next_o (cx_word)
  );

  // Read mux over the slot file.
  always_comb begin
    restore_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_hit[i]) restore_word = slot_mem_q[i];
    end
  end

  // Next-state, per-iteration datapath update and handshake outputs.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    dir_d         = dir_q;
    slot_d        = slot_q;
    word_d        = word_q;
    iter_d        = iter_q;
    pe_d          = pe_q;
    done_d        = (state_q == ST_DONE);
    save_en       = 1'b0;
    busy          = 1'b0;
    cmd.cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted.
        cmd.cmd_ready = rst;
        if (cmd.cmd_valid && rst) begin
          op_d    = op_e'(cmd.cmd_op);
          dir_d   = dir_e'(cmd.cmd_dir);
          slot_d  = cmd.cmd_slot;
          word_d  = cmd.cmd_word;
          iter_d  = (cmd.cmd_count == '0) ? '0 : cmd.cmd_count - CNT_WIDTH'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        case (op_q)
          OP_LOAD:    pe_d = word_q;
          OP_SHIFT,
          OP_CX_MIN,
          OP_CX_MAX:  pe_d = cx_word;
          OP_SAVE:    save_en = 1'b1;
          OP_RESTORE: pe_d = restore_word;
          default:    pe_d = pe_q;
        endcase
        if (iter_q == '0) state_d = ST_DONE;
        else              iter_d  = iter_q - CNT_WIDTH'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, held command and PE word; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      dir_q   <= DIR_L;
      slot_q  <= '0;
      word_q  <= '0;
      iter_q  <= '0;
      pe_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
      iter_q  <= iter_d;
      pe_q    <= pe_d;
      done_q  <= done_d;
    end
  end

  // Slot file: cleared on reset, written by SAVE iterations.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) slot_mem_q[i] <= '0;
    end else if (save_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_hit[i]) slot_mem_q[i] <= pe_q;
      end
    end
  end

  assign o_PE = pe_q;
  assign done = done_q;

endmodule

// File: tb/tb_nanci_pe_seq.sv
// Bench for nanci_pe_seq: table of commands with a scoreboard of expected
// results, plus hand-written sequences for repeat, handshake and reset cases.
module tb_nanci_pe_seq;
  import nanci_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] pe_l, pe_r, pe_u, pe_d;
  logic [5:0] o_pe;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  nanci_pe_seq_if #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .DEPTH(3), .CNT_WIDTH(8)) ifc ();

  nanci_pe_seq #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .DEPTH(3), .CNT_WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (ifc),
    .i_PE_l (pe_l),
    .i_PE_r (pe_r),
    .i_PE_u (pe_u),
    .i_PE_d (pe_d),
    .o_PE   (o_pe),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] dir;
    logic [1:0] slot;
    logic [7:0] cnt;
    logic [5:0] word;
    logic [5:0] l, r, u, d;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    logic [5:0] exp_pe;
    int         exp_busy;
  } sb_t;

  vec_t vecs [28];
  sb_t  sb [$];

  function automatic logic [5:0] w(input int a, input int d);
    logic [2:0] aa, dd;
    aa = a[2:0];
    dd = d[2:0];
    return {aa, dd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!ifc.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_wait"}, 32'(ifc.cmd_ready), 32'd1);
  endtask

  // Issue one command, push the expected result, then wait for done and
  // compare against the popped scoreboard entry.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] dir, input logic [1:0] slot,
                         input logic [7:0] cnt, input logic [5:0] word, input logic [5:0] exp_pe,
                         input string tag);
    sb_t e;
    sb_t got;
    int  guard;
    int  busy_n;
    @(negedge clk);
    wait_ready(tag);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_dir   = dir;
    ifc.cmd_slot  = slot;
    ifc.cmd_count = cnt;
    ifc.cmd_word  = word;
    e.exp_pe   = exp_pe;
    e.exp_busy = (cnt == 8'd0) ? 1 : int'(cnt);
    sb.push_back(e);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    busy_n = 0;
    guard  = 0;
    while (!done && guard < 400) begin
      if (busy) busy_n++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    got = sb.pop_front();
    check({tag, "_pe"}, 32'(o_pe), 32'(got.exp_pe));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(got.exp_busy));
    check({tag, "_ready_after"}, 32'(ifc.cmd_ready), 32'd1);
    $display("txn %s op=%0d dir=%0d cnt=%0d o_PE=0x%02h busy_cycles=%0d", tag, op, dir, cnt, o_pe, busy_n);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{OP_SHIFT,   DIR_D, 2'd0, 8'd0,   6'h00, w(0,1), w(0,2), w(0,3), w(0,4), w(0,4)};
    vecs[1]  = '{OP_LOAD,    DIR_L, 2'd0, 8'd0,   w(5,6), w(0,1), w(0,2), w(0,3), w(0,4), w(5,6)};
    vecs[2]  = '{OP_CX_MIN,  DIR_L, 2'd0, 8'd0,   6'h00, w(1,2), w(0,0), w(0,0), w(0,0), w(1,2)};
    vecs[3]  = '{OP_CX_MAX,  DIR_L, 2'd0, 8'd0,   6'h00, w(1,2), w(0,7), w(0,7), w(0,7), w(1,2)};
    vecs[4]  = '{OP_LOAD,    DIR_L, 2'd0, 8'd2,   w(7,2), w(0,0), w(0,0), w(0,0), w(0,0), w(7,2)};
    vecs[5]  = '{OP_CX_MIN,  DIR_L, 2'd0, 8'd0,   6'h00, w(1,2), w(0,7), w(0,7), w(0,7), w(7,2)};
    vecs[6]  = '{OP_CX_MAX,  DIR_L, 2'd0, 8'd0,   6'h00, w(1,2), w(0,0), w(0,0), w(0,0), w(7,2)};
    vecs[7]  = '{OP_CX_MAX,  DIR_U, 2'd0, 8'd0,   6'h00, w(0,7), w(0,7), w(3,5), w(0,7), w(3,5)};
    vecs[8]  = '{OP_CX_MIN,  DIR_R, 2'd0, 8'd0,   6'h00, w(0,0), w(4,1), w(0,0), w(0,0), w(4,1)};
    vecs[9]  = '{OP_CX_MIN,  DIR_D, 2'd0, 8'd5,   6'h00, w(0,0), w(0,0), w(0,0), w(0,7), w(4,1)};
    vecs[10] = '{OP_LOAD,    DIR_L, 2'd0, 8'd3,   6'h2A, w(0,0), w(0,0), w(0,0), w(0,0), 6'h2A};
    vecs[11] = '{OP_SAVE,    DIR_L, 2'd2, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h2A};
    vecs[12] = '{OP_LOAD,    DIR_L, 2'd0, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h00};
    vecs[13] = '{OP_RESTORE, DIR_L, 2'd2, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h2A};
    vecs[14] = '{OP_SAVE,    DIR_L, 2'd3, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h2A};
    vecs[15] = '{OP_RESTORE, DIR_L, 2'd3, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h00};
    vecs[16] = '{OP_RESTORE, DIR_L, 2'd2, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h2A};
    vecs[17] = '{OP_NOP,     DIR_L, 2'd0, 8'd4,   w(1,1), w(0,5), w(0,5), w(0,5), w(0,5), 6'h2A};
    vecs[18] = '{OP_RSVD,    DIR_R, 2'd0, 8'd2,   w(1,1), w(0,5), w(0,5), w(0,5), w(0,5), 6'h2A};
    vecs[19] = '{OP_RESTORE, DIR_L, 2'd0, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h00};
    vecs[20] = '{OP_SHIFT,   DIR_L, 2'd0, 8'd0,   6'h00, w(6,3), w(0,0), w(0,0), w(0,0), w(6,3)};
    vecs[21] = '{OP_CX_MAX,  DIR_R, 2'd0, 8'd0,   6'h00, w(0,0), w(2,7), w(0,0), w(0,0), w(2,7)};
    vecs[22] = '{OP_CX_MIN,  DIR_U, 2'd0, 8'd0,   6'h00, w(0,0), w(0,0), w(5,0), w(0,0), w(5,0)};
    vecs[23] = '{OP_CX_MAX,  DIR_D, 2'd0, 8'd255, 6'h00, w(0,0), w(0,0), w(0,0), w(1,7), w(1,7)};
    vecs[24] = '{OP_SAVE,    DIR_L, 2'd1, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), w(1,7)};
    vecs[25] = '{OP_RESTORE, DIR_L, 2'd0, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), 6'h00};
    vecs[26] = '{OP_RESTORE, DIR_L, 2'd1, 8'd0,   6'h00, w(0,0), w(0,0), w(0,0), w(0,0), w(1,7)};
    vecs[27] = '{OP_CX_MIN,  DIR_L, 2'd0, 8'd0,   6'h00, w(3,6), w(0,0), w(0,0), w(0,0), w(3,6)};

    rst = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 3'd0;
    ifc.cmd_dir   = 2'd0;
    ifc.cmd_slot  = 2'd0;
    ifc.cmd_count = 8'd0;
    ifc.cmd_word  = 6'd0;
    pe_l = 6'd0; pe_r = 6'd0; pe_u = 6'd0; pe_d = 6'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_o_PE", 32'(o_pe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ifc.cmd_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(ifc.cmd_ready), 32'd1);

    // Table-driven commands.
    for (int i = 0; i < 28; i++) begin
      pe_l = vecs[i].l;
      pe_r = vecs[i].r;
      pe_u = vecs[i].u;
      pe_d = vecs[i].d;
      run_cmd(vecs[i].op, vecs[i].dir, vecs[i].slot, vecs[i].cnt, vecs[i].word,
              vecs[i].exp, $sformatf("v%0d", i));
    end

    // Repeat count: o_PE follows a neighbour that changes every cycle.
    @(negedge clk);
    wait_ready("rep");
    pe_r = w(7,7);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = OP_SHIFT; ifc.cmd_dir = DIR_R; ifc.cmd_count = 8'd3;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("rep_busy0", 32'(busy), 32'd1);
    for (int j = 1; j <= 3; j++) begin
      pe_r = w(0, j);
      @(negedge clk);
      check($sformatf("rep_pe%0d", j), 32'(o_pe), 32'(w(0, j)));
      check($sformatf("rep_busy%0d", j), 32'(busy), (j < 3) ? 32'd1 : 32'd0);
      check($sformatf("rep_done%0d", j), 32'(done), 32'd0);
    end
    @(negedge clk);
    check("rep_done", 32'(done), 32'd1);
    $display("txn rep SHIFT R cnt=3 o_PE=0x%02h", o_pe);

    // Handshake: valid held high, dir wiggles during RUN and DONE.
    pe_l = w(1,1); pe_r = w(2,2); pe_u = w(3,3); pe_d = w(4,4);
    @(negedge clk);
    wait_ready("hs");
    ifc.cmd_valid = 1'b1; ifc.cmd_op = OP_SHIFT; ifc.cmd_dir = DIR_L; ifc.cmd_count = 8'd3;
    @(negedge clk);
    ifc.cmd_dir = DIR_U; ifc.cmd_count = 8'd1;
    check("hs_busy", 32'(busy), 32'd1);
    check("hs_ready_run", 32'(ifc.cmd_ready), 32'd0);
    @(negedge clk);
    check("hs_pe1", 32'(o_pe), 32'(w(1,1)));
    ifc.cmd_dir = DIR_R;
    @(negedge clk);
    check("hs_pe2", 32'(o_pe), 32'(w(1,1)));
    ifc.cmd_dir = DIR_U;
    @(negedge clk);
    check("hs_pe3", 32'(o_pe), 32'(w(1,1)));
    check("hs_ready_done", 32'(ifc.cmd_ready), 32'd0);
    ifc.cmd_dir = DIR_D; ifc.cmd_count = 8'd0;
    @(negedge clk);
    check("hs_done", 32'(done), 32'd1);
    check("hs_ready_idle", 32'(ifc.cmd_ready), 32'd1);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("hs_second_busy", 32'(busy), 32'd1);
    check("hs_second_hold", 32'(o_pe), 32'(w(1,1)));
    @(negedge clk);
    check("hs_second_pe", 32'(o_pe), 32'(w(4,4)));
    @(negedge clk);
    check("hs_second_done", 32'(done), 32'd1);
    $display("txn hs second SHIFT D o_PE=0x%02h", o_pe);

    // Reset in the middle of a long SHIFT.
    pe_d = w(2,5);
    @(negedge clk);
    wait_ready("mid");
    ifc.cmd_valid = 1'b1; ifc.cmd_op = OP_SHIFT; ifc.cmd_dir = DIR_D; ifc.cmd_count = 8'd10;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_pe_before", 32'(o_pe), 32'(w(2,5)));
    check("mid_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_pe_reset", 32'(o_pe), 32'd0);
    check("mid_busy_reset", 32'(busy), 32'd0);
    check("mid_done_reset", 32'(done), 32'd0);
    check("mid_ready_reset", 32'(ifc.cmd_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ready_release", 32'(ifc.cmd_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("mid_no_done%0d", j), 32'(done), 32'd0);
      @(negedge clk);
    end
    $display("txn mid reset abort o_PE=0x%02h", o_pe);
    run_cmd(OP_RESTORE, DIR_L, 2'd2, 8'd0, 6'h00, 6'h00, "post_restore");
    run_cmd(OP_SHIFT, DIR_D, 2'd0, 8'd2, 6'h00, w(2,5), "post_shift");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
